pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Next-PC sequencer driving the program-counter register: chooses sequential, jump, branch,
//  interrupt-entry, mret-return or soft-reset target each cycle and produces pc_next/pc_we.
//  Holds redirects that arrive during fetch/memory/CSR stalls and applies them once the stall clears.
//  Runs a single-level interrupt entry/exit FSM and generates IF/ID flushes. Sits between CSR unit, EX branch unit and PC register.
// PARAMETERS
//  XLEN      32       PC/target width
//  RESET_PC  32'h0    value driven on reset and sw_reset
//  PC_STEP   4        sequential increment
// PORTS
//  clk            in   1     clock; single clock domain
//  reset          in   1     synchronous, active-low reset
//  pc_cur         in   XLEN  current PC register value
//  im_stall       in   1     instruction-memory stall
//  dm_stall       in   1     data-memory stall
//  csr_stall      in   1     CSR unit stall
//  jal_valid      in   1     ID-stage jump resolved
//  jal_target     in   XLEN  jump target
//  br_taken       in   1     EX-stage branch taken / mispredict
//  br_target      in   XLEN  branch target
//  irq_req        in   1     level interrupt request from CSR unit
//  irq_vec        in   XLEN  ISR entry address
//  mret_req       in   1     return-from-ISR request
//  mret_pc        in   XLEN  return address
//  sw_reset       in   1     CSR soft reset
//  pc_next        out  XLEN  value loaded into PC register
//  pc_we          out  1     PC register write enable
//  flush_if       out  1     kill IF-stage instruction
//  flush_id       out  1     kill ID-stage instruction
//  irq_ack        out  1     one-cycle pulse: ISR vector committed
//  in_isr         out  1     FSM in ENTER or ISR
//  redir_pend     out  1     a held redirect is waiting for stall release
//  pc_misalign    out  1     target misalignment pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): FSM=IDLE, pending cleared; registered outputs reset to pc_next=RESET_PC,
//    pc_we=0, irq_ack=0, in_isr=0, redir_pend=0, pc_misalign=0; flush_if/flush_id deassert the same cycle.
//    Reset mid-stall discards any pending redirect.
//  - stall = im_stall|dm_stall|csr_stall. Priority: sw_reset > mret > irq > br > jal > seq (pc_cur+PC_STEP).
//  - sw_reset: pc_next=RESET_PC, pc_we=1, flush_if=flush_id=1, FSM->IDLE, pending cleared; overrides stall.
//  - No stall, no pending: winner applied combinationally same cycle; pc_we=1.
//  - Stall: pc_we=0; highest-priority non-seq event is latched (kind+target) into pending; a later event
//    replaces pending only if strictly higher priority; equal/lower priority is dropped.
//  - Stall release with pending: pending target applied, pc_we=1, pending cleared; new same-cycle events
//    of higher priority than pending win, others dropped.
//  - Flushes (only in commit cycle): jal -> flush_if; br/irq/mret/sw_reset -> flush_if+flush_id.
//  - Arithmetic: pc_cur+PC_STEP wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0).
//  - IRQ FSM: IDLE -(irq_req)-> ENTER; ENTER holds until no stall, then commits irq_vec, irq_ack=1 -> ISR;
//    ISR -(mret commit)-> EXIT; EXIT -> IDLE after 1 cycle (irq_req ignored in EXIT: re-arm guard).
//    irq_req ignored in ISR (no nesting). mret_req outside ISR treated as ordinary redirect, FSM unchanged.
//    irq_req dropping in ENTER aborts back to IDLE with no ack.
// CONFIGURATION
//  PC_MISALIGN_CHK_EN defined: target with nonzero bits[1:0] forces those bits to 0 in pc_next and
//    pulses pc_misalign for the commit cycle.
//  Not defined: targets passed unmodified; pc_misalign tied 0.
// STRUCTURE
//  Package pc_ctrl_pkg: redir_kind_e {RK_SEQ,RK_JAL,RK_BR,RK_IRQ,RK_MRET,RK_RST}, irq_state_e
//    {IRQ_IDLE,IRQ_ENTER,IRQ_ISR,IRQ_EXIT}, priority-compare function.
//  Sub-module pc_redirect_arb: combinational priority pick of {kind,target} from live requests + pending.
// TESTING
//  1 Free run, no events, pc_cur=32'h100 -> pc_next=32'h104, pc_we=1 each cycle; pc_cur=32'hFFFF_FFFC -> 0.
//  2 im_stall 3 cycles, br_taken target 32'h200 in cycle 1 -> pc_we=0, redir_pend=1; on release pc_next=32'h200, flush_if/id=1.
//  3 Stall with jal 32'h300 then br 32'h400 -> 32'h400 applied; reverse order -> still 32'h400.
//  4 irq_req with dm_stall 2 cycles, irq_vec=32'h800 -> no ack while stalled; then irq_ack pulse, pc_next=32'h800,
//    in_isr=1; irq_req held -> no second ack; mret_pc=32'h104 -> pc_next=32'h104, IDLE after EXIT.
//  5 sw_reset during stall with pending br -> pc_next=RESET_PC, pc_we=1, redir_pend=0; reset=0 mid-ENTER -> IDLE, outputs reset values.
//  6 PC_MISALIGN_CHK_EN: br_target 32'h202 -> pc_next=32'h200, pc_misalign=1 one cycle; macro off -> 32'h202, pc_misalign=0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared types for the next-PC sequencer:
//   redir_kind_e  - redirect source. The encoding order is the priority order:
//                   a larger value beats a smaller one.
//   irq_state_e   - single-level interrupt entry/exit FSM states.
//   rk_higher()   - strict priority compare between two redirect kinds.
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        RK_SEQ  = 3'd0,
        RK_JAL  = 3'd1,
        RK_BR   = 3'd2,
        RK_IRQ  = 3'd3,
        RK_MRET = 3'd4,
        RK_RST  = 3'd5
    } redir_kind_e;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_ENTER = 2'd1,
        IRQ_ISR   = 2'd2,
        IRQ_EXIT  = 2'd3
    } irq_state_e;

    // True when kind a strictly outranks kind b. An equal kind never wins,
    // so a second request of the same kind cannot displace a held one.
    function automatic logic rk_higher(input redir_kind_e a, input redir_kind_e b);
        return a > b;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// -----------------------------------------------------------------------------
// pc_redirect_arb
// Combinational priority pick of the next-PC source.
//
// Ports:
//   pc_cur                       current PC (sequential target = pc_cur+PC_STEP)
//   sw_reset                     soft reset request (target RESET_PC)
//   mret_req / mret_pc           return-from-ISR request and address
//   irq_live / irq_vec           interrupt ready to commit and its vector
//   br_taken / br_target         EX branch redirect
//   jal_valid / jal_target       ID jump redirect
//   pend_valid/kind/target       redirect held from an earlier stall
//   sel_kind / sel_target        winner to commit when the PC is written
//   hold_kind / hold_target      best live redirect eligible to be held
//                                through a stall (mret/br/jal only)
// -----------------------------------------------------------------------------
module pc_redirect_arb
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic [XLEN-1:0] pc_cur,
    input  logic            sw_reset,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mret_pc,
    input  logic            irq_live,
    input  logic [XLEN-1:0] irq_vec,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jal_valid,
    input  logic [XLEN-1:0] jal_target,
    input  logic            pend_valid,
    input  redir_kind_e     pend_kind,
    input  logic [XLEN-1:0] pend_target,
    output redir_kind_e     sel_kind,
    output logic [XLEN-1:0] sel_target,
    output redir_kind_e     hold_kind,
    output logic [XLEN-1:0] hold_target
);

    logic [XLEN-1:0] seq_target;
    redir_kind_e     live_kind;
    logic [XLEN-1:0] live_target;
    redir_kind_e     cand_kind;
    logic [XLEN-1:0] cand_target;

    // Wraps modulo 2^XLEN by construction.
    assign seq_target = pc_cur + XLEN'(PC_STEP);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned (which would infer a latch); blocking '=' is
    // used here because later statements must see the earlier values.
    always_comb begin
        // Held-through-stall candidates, lowest priority first so the last
        // true condition leaves the highest-priority request in place.
        hold_kind   = RK_SEQ;
        hold_target = seq_target;
        if (jal_valid) begin
            hold_kind   = RK_JAL;
            hold_target = jal_target;
        end
        if (br_taken) begin
            hold_kind   = RK_BR;
            hold_target = br_target;
        end
        if (mret_req) begin
            hold_kind   = RK_MRET;
            hold_target = mret_pc;
        end

        // The interrupt is tracked by the FSM rather than the pending slot,
        // so it only joins the live set here.
        live_kind   = hold_kind;
        live_target = hold_target;
        if (irq_live && rk_higher(RK_IRQ, live_kind)) begin
            live_kind   = RK_IRQ;
            live_target = irq_vec;
        end
        if (sw_reset) begin
            live_kind   = RK_RST;
            live_target = RESET_PC;
        end

        cand_kind   = pend_valid ? pend_kind   : RK_SEQ;
        cand_target = pend_valid ? pend_target : seq_target;

        // A live request must strictly outrank the held one to replace it.
        if (rk_higher(live_kind, cand_kind)) begin
            sel_kind   = live_kind;
            sel_target = live_target;
        end else begin
            sel_kind   = cand_kind;
            sel_target = cand_target;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
// Next-PC sequencer for the program-counter register. Each cycle it chooses
// among sequential, jump, branch, interrupt-entry, mret-return and soft-reset
// targets, holds a redirect that arrives while the pipeline is stalled and
// applies it once the stall clears, and runs a single-level interrupt
// entry/exit FSM.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   pc_cur                current PC register value
//   im/dm/csr_stall       stall sources; any one blocks the PC write
//   jal_*, br_*           jump / branch redirects
//   irq_req, irq_vec      level interrupt request and ISR entry address
//   mret_req, mret_pc     return-from-ISR request and address
//   sw_reset              CSR soft reset (overrides stalls)
//   pc_next, pc_we        value and write enable for the PC register
//   flush_if, flush_id    kill IF / ID instructions on a committed redirect
//   irq_ack               one-cycle pulse when the ISR vector commits
//   in_isr                FSM is in ENTER or ISR
//   redir_pend            a held redirect is waiting for stall release
//   pc_misalign           committed target had nonzero low bits
//
// Build option: define PC_MISALIGN_CHK_EN to clear bits [1:0] of a committed
// target and pulse pc_misalign; otherwise targets pass unmodified and
// pc_misalign is tied low.
// -----------------------------------------------------------------------------
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    input  logic            im_stall,
    input  logic            dm_stall,
    input  logic            csr_stall,
    input  logic            jal_valid,
    input  logic [XLEN-1:0] jal_target,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            irq_req,
    input  logic [XLEN-1:0] irq_vec,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mret_pc,
    input  logic            sw_reset,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_we,
    output logic            flush_if,
    output logic            flush_id,
    output logic            irq_ack,
    output logic            in_isr,
    output logic            redir_pend,
    output logic            pc_misalign
);

    irq_state_e      state_q, state_d;
    logic            pend_valid_q;
    redir_kind_e     pend_kind_q;
    logic [XLEN-1:0] pend_target_q;

    logic            stall;
    logic            commit;
    logic            irq_live;
    redir_kind_e     sel_kind;
    logic [XLEN-1:0] sel_target;
    redir_kind_e     hold_kind;
    logic [XLEN-1:0] hold_target;
    logic [XLEN-1:0] commit_target;
    logic            misalign;

    assign stall    = im_stall | dm_stall | csr_stall;
    // Soft reset writes the PC even while stalled.
    assign commit   = sw_reset | ~stall;
    // An interrupt is only offered for commit once the FSM has entered ENTER;
    // dropping irq_req there withdraws it.
    assign irq_live = (state_q == IRQ_ENTER) && irq_req;

    pc_redirect_arb #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_arb (
        .pc_cur      (pc_cur),
        .sw_reset    (sw_reset),
        .mret_req    (mret_req),
        .mret_pc     (mret_pc),
        .irq_live    (irq_live),
        .irq_vec     (irq_vec),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jal_valid   (jal_valid),
        .jal_target  (jal_target),
        .pend_valid  (pend_valid_q),
        .pend_kind   (pend_kind_q),
        .pend_target (pend_target_q),
        .sel_kind    (sel_kind),
        .sel_target  (sel_target),
        .hold_kind   (hold_kind),
        .hold_target (hold_target)
    );

`ifdef PC_MISALIGN_CHK_EN
    always_comb begin
        commit_target = sel_target;
        misalign      = 1'b0;
        if (sel_target[1:0] != 2'b00) begin
            commit_target[1:0] = 2'b00;
            misalign           = 1'b1;
        end
    end
`else
    assign commit_target = sel_target;
    assign misalign      = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_valid_q  <= 1'b0;
            pend_kind_q   <= RK_SEQ;
            pend_target_q <= '0;
        end else if (commit) begin
            pend_valid_q  <= 1'b0;
        end else if (hold_kind != RK_SEQ &&
                     (!pend_valid_q || rk_higher(hold_kind, pend_kind_q))) begin
            pend_valid_q  <= 1'b1;
            pend_kind_q   <= hold_kind;
            pend_target_q <= hold_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IRQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw_reset) begin
            state_d = IRQ_IDLE;
        end else begin
            unique case (state_q)
                IRQ_IDLE: begin
                    if (irq_req) state_d = IRQ_ENTER;
                end
                IRQ_ENTER: begin
                    if (!irq_req)
                        state_d = IRQ_IDLE;
                    else if (commit && sel_kind == RK_IRQ)
                        state_d = IRQ_ISR;
                end
                IRQ_ISR: begin
                    // irq_req is not looked at here: no nesting.
                    if (commit && sel_kind == RK_MRET) state_d = IRQ_EXIT;
                end
                IRQ_EXIT: begin
                    // One cycle with irq_req ignored so a still-high level
                    // request does not immediately re-enter.
                    state_d = IRQ_IDLE;
                end
                default: state_d = IRQ_IDLE;
            endcase
        end
    end

    // While reset is held every output shows its reset value.
    always_comb begin
        pc_next     = RESET_PC;
        pc_we       = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        irq_ack     = 1'b0;
        pc_misalign = 1'b0;
        if (reset) begin
            pc_next = commit ? commit_target : pc_cur;
            if (commit) begin
                pc_we       = 1'b1;
                pc_misalign = misalign;
                irq_ack     = (sel_kind == RK_IRQ);
                flush_if    = (sel_kind != RK_SEQ);
                flush_id    = (sel_kind == RK_BR)   || (sel_kind == RK_IRQ) ||
                              (sel_kind == RK_MRET) || (sel_kind == RK_RST);
            end
        end
    end

    assign in_isr     = reset && (state_q == IRQ_ENTER || state_q == IRQ_ISR);
    assign redir_pend = reset && pend_valid_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
// Self-checking bench for pc_redirect_ctrl. Each cycle the expected output
// set is pushed to a scoreboard as the inputs are driven, then popped and
// compared at the following falling edge. pc_next is only compared in cycles
// where a PC write is expected.
// Honours PC_MISALIGN_CHK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic        fif;
        logic        fid;
        logic        ack;
        logic        isr;
        logic        pend;
        logic        mis;
    } exp_t;

`ifdef PC_MISALIGN_CHK_EN
    localparam logic [31:0] MIS_PC   = 32'h0000_0200;
    localparam logic        MIS_FLAG = 1'b1;
`else
    localparam logic [31:0] MIS_PC   = 32'h0000_0202;
    localparam logic        MIS_FLAG = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc_cur;
    logic        im_stall, dm_stall, csr_stall;
    logic        jal_valid;
    logic [31:0] jal_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        irq_req;
    logic [31:0] irq_vec;
    logic        mret_req;
    logic [31:0] mret_pc;
    logic        sw_reset;
    logic [31:0] pc_next;
    logic        pc_we, flush_if, flush_id, irq_ack, in_isr, redir_pend, pc_misalign;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";
    exp_t  sb_q[$];

    pc_redirect_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_cur      (pc_cur),
        .im_stall    (im_stall),
        .dm_stall    (dm_stall),
        .csr_stall   (csr_stall),
        .jal_valid   (jal_valid),
        .jal_target  (jal_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .irq_req     (irq_req),
        .irq_vec     (irq_vec),
        .mret_req    (mret_req),
        .mret_pc     (mret_pc),
        .sw_reset    (sw_reset),
        .pc_next     (pc_next),
        .pc_we       (pc_we),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .irq_ack     (irq_ack),
        .in_isr      (in_isr),
        .redir_pend  (redir_pend),
        .pc_misalign (pc_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        im_stall   = 1'b0; dm_stall  = 1'b0; csr_stall = 1'b0;
        jal_valid  = 1'b0; br_taken  = 1'b0; irq_req   = 1'b0;
        mret_req   = 1'b0; sw_reset  = 1'b0;
    endtask

    // Push the expectation for the inputs just driven, compare at the falling
    // edge, then advance past the next rising edge.
    task automatic run_cycle(input logic [31:0] pc, input logic we, input logic fif,
                             input logic fid, input logic ack, input logic isr,
                             input logic pend, input logic mis);
        exp_t e;
        exp_t got_e;
        e.pc = pc; e.we = we; e.fif = fif; e.fid = fid;
        e.ack = ack; e.isr = isr; e.pend = pend; e.mis = mis;
        sb_q.push_back(e);
        @(negedge clk);
        got_e = sb_q.pop_front();
        if (got_e.we) check({phase, ".pc_next"}, pc_next, got_e.pc);
        check({phase, ".pc_we"},       32'(pc_we),       32'(got_e.we));
        check({phase, ".flush_if"},    32'(flush_if),    32'(got_e.fif));
        check({phase, ".flush_id"},    32'(flush_id),    32'(got_e.fid));
        check({phase, ".irq_ack"},     32'(irq_ack),     32'(got_e.ack));
        check({phase, ".in_isr"},      32'(in_isr),      32'(got_e.isr));
        check({phase, ".redir_pend"},  32'(redir_pend),  32'(got_e.pend));
        check({phase, ".pc_misalign"}, 32'(pc_misalign), 32'(got_e.mis));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        clr_in();
        pc_cur = 32'h100; jal_target = '0; br_target = '0;
        irq_vec = '0; mret_pc = '0;
        @(posedge clk); #1;

        // Reset state
        phase = "reset";
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        // 1: free run and wrap
        phase = "seq";
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);
        phase = "wrap";
        pc_cur = 32'hFFFF_FFFC;
        run_cycle(32'h0, 1, 0, 0, 0, 0, 0, 0);
        pc_cur = 32'h100;

        // Unstalled redirects
        phase = "jal";
        jal_valid = 1; jal_target = 32'h300;
        run_cycle(32'h300, 1, 1, 0, 0, 0, 0, 0);
        phase = "br_over_jal";
        br_taken = 1; br_target = 32'h400;
        run_cycle(32'h400, 1, 1, 1, 0, 0, 0, 0);
        clr_in();
        phase = "mret_idle";
        mret_req = 1; mret_pc = 32'h500;
        run_cycle(32'h500, 1, 1, 1, 0, 0, 0, 0);
        clr_in();
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        // 2: stalled branch held for three cycles
        phase = "stall_br";
        im_stall = 1; br_taken = 1; br_target = 32'h200;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 0;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        run_cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        im_stall = 0;
        run_cycle(32'h200, 1, 1, 1, 0, 0, 1, 0);
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        // 3: priority among held redirects
        phase = "jal_then_br";
        csr_stall = 1; jal_valid = 1; jal_target = 32'h300;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        jal_valid = 0; br_taken = 1; br_target = 32'h400;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        clr_in();
        run_cycle(32'h400, 1, 1, 1, 0, 0, 1, 0);
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        phase = "br_then_jal";
        csr_stall = 1; br_taken = 1; br_target = 32'h400;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 0; jal_valid = 1; jal_target = 32'h300;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        csr_stall = 0;   // jal still live on release: lower, dropped
        run_cycle(32'h400, 1, 1, 1, 0, 0, 1, 0);
        clr_in();
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        phase = "equal_drop";
        dm_stall = 1; br_taken = 1; br_target = 32'h400;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        br_target = 32'h500;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        clr_in();
        run_cycle(32'h400, 1, 1, 1, 0, 0, 1, 0);

        phase = "release_higher";
        dm_stall = 1; br_taken = 1; br_target = 32'h400;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        clr_in(); mret_req = 1; mret_pc = 32'h600;
        run_cycle(32'h600, 1, 1, 1, 0, 0, 1, 0);
        clr_in();
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        // 4: interrupt entry under stall, ISR, mret, exit guard, abort
        phase = "irq";
        irq_req = 1; irq_vec = 32'h800; dm_stall = 1;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(32'h0, 0, 0, 0, 0, 1, 0, 0);
        dm_stall = 0;
        run_cycle(32'h800, 1, 1, 1, 1, 1, 0, 0);
        pc_cur = 32'h800;
        run_cycle(32'h804, 1, 0, 0, 0, 1, 0, 0);
        irq_req = 0; mret_req = 1; mret_pc = 32'h104;
        run_cycle(32'h104, 1, 1, 1, 0, 1, 0, 0);
        mret_req = 0; irq_req = 1; pc_cur = 32'h104;
        run_cycle(32'h108, 1, 0, 0, 0, 0, 0, 0);
        pc_cur = 32'h108;
        run_cycle(32'h10C, 1, 0, 0, 0, 0, 0, 0);
        phase = "irq_abort";
        irq_req = 0;
        run_cycle(32'h10C, 1, 0, 0, 0, 1, 0, 0);
        run_cycle(32'h10C, 1, 0, 0, 0, 0, 0, 0);
        pc_cur = 32'h100;

        // 5: soft reset over a stall with a held branch
        phase = "sw_reset";
        im_stall = 1; br_taken = 1; br_target = 32'h200;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 0; sw_reset = 1;
        run_cycle(32'h0, 1, 1, 1, 0, 0, 1, 0);
        sw_reset = 0;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        im_stall = 0;
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        // Hard reset while in ENTER with a held branch
        phase = "reset_enter";
        irq_req = 1; irq_vec = 32'h800; dm_stall = 1; br_taken = 1; br_target = 32'h200;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        run_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1; clr_in();
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        // 6: misaligned target
        phase = "misalign";
        br_taken = 1; br_target = 32'h202;
        run_cycle(MIS_PC, 1, 1, 1, 0, 0, 0, MIS_FLAG);
        clr_in();
        run_cycle(32'h104, 1, 0, 0, 0, 0, 0, 0);

        phase = "end";
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
